change_dispenser: RTL

- Physical-output end of the refund path. Takes a refund amount in cents and drives the quarter, dime and nickel eject solenoids one coin at a time.
- Decomposes the amount greedily: largest coin that fits.
- Each eject is a timed pulse followed by a mechanical settle gap.
- Sits after the credit/refund logic in the vending top. Reports Busy/Done back to it so credit is cleared only after the change has physically left.

---
 rtl/vend_pkg.sv | 39 +++
 rtl/change_dispenser_if.sv | 44 ++++
 rtl/pulse_timer.sv | 26 ++
 rtl/change_dispenser.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared vending types: coin denominations, dispenser states, cent values.
// Helpers for coin value lookup and refund amount validation.
package vend_pkg;

  typedef enum logic [1:0] {
    COIN_Q,
    COIN_D,
    COIN_N
  } coin_e;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    PULSE,
    GAP,
    DONE
  } disp_state_e;

  localparam logic [6:0] CENTS_Q    = 7'd25;
  localparam logic [6:0] CENTS_D    = 7'd10;
  localparam logic [6:0] CENTS_N    = 7'd5;
  localparam logic [6:0] MAX_CREDIT = 7'd99;

  function automatic logic [6:0] coin_cents(coin_e c);
    logic [6:0] v;
    v = CENTS_N;
    unique case (c)
      COIN_Q:  v = CENTS_Q;
      COIN_D:  v = CENTS_D;
      default: v = CENTS_N;
    endcase
    return v;
  endfunction

  function automatic logic amount_ok(logic [6:0] a);
    return (a <= MAX_CREDIT) && ((a % 7'd5) == 7'd0);
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Refund request / dispenser status bundle.
// COIN_INVENTORY_EN adds the restock request line.
interface change_dispenser_if;
  logic       start;
  logic [6:0] amount;
`ifdef COIN_INVENTORY_EN
  logic       restock;
`endif
  logic       busy;
  logic       done;
  logic       error;
  logic       eject_q;
  logic       eject_d;
  logic       eject_n;
  logic [6:0] remaining;

`ifdef COIN_INVENTORY_EN
  modport master (
    output start, amount, restock,
    input  busy, done, error,
    input  eject_q, eject_d, eject_n,
    input  remaining
  );
  modport slave (
    input  start, amount, restock,
    output busy, done, error,
    output eject_q, eject_d, eject_n,
    output remaining
  );
`else
  modport master (
    output start, amount,
    input  busy, done, error,
    input  eject_q, eject_d, eject_n,
    input  remaining
  );
  modport slave (
    input  start, amount,
    output busy, done, error,
    output eject_q, eject_d, eject_n,
    output remaining
  );
`endif
endinterface

// File: rtl/pulse_timer.sv
// Loadable down-counter with zero flag.
// Shared by the eject pulse and settle gap phases.
module pulse_timer #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)
      cnt_q <= '0;
    else if (load_i)
      cnt_q <= val_i;
    else if (cnt_q != '0)
      cnt_q <= cnt_q - 1'b1;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// Greedy coin ejector driving quarter/dime/nickel solenoids.
// COIN_INVENTORY_EN adds finite per-coin stock with restock.
import vend_pkg::*;

module change_dispenser #(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 4
`ifdef COIN_INVENTORY_EN
  ,
  parameter int STOCK_INIT   = 15
`endif
) (
  input  logic                clk_i,
  input  logic                rst_i,
  change_dispenser_if.slave   bus
);

  localparam int TW = 16;

  disp_state_e state_q, state_d;
  coin_e       coin_q, coin_d;
  logic [6:0]  rem_q, rem_d;
  logic        err_q, err_d;
  logic        eq_q, ed_q, en_q;
  logic        eq_d, ed_d, en_d;
  logic        tload;
  logic [TW-1:0] tval;
  logic        tzero;
  logic        ok_q, ok_d, ok_n;
  logic        rem_zero, none_fit;

  pulse_timer #(.W(TW)) u_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (tload),
    .val_i  (tval),
    .zero_o (tzero)
  );

`ifdef COIN_INVENTORY_EN
  logic [3:0] sq_q, sd_q, sn_q;
  logic [3:0] sq_d, sd_d, sn_d;

  assign ok_q     = (rem_q >= CENTS_Q) && (sq_q != 4'd0);
  assign ok_d     = (rem_q >= CENTS_D) && (sd_q != 4'd0);
  assign ok_n     = (rem_q >= CENTS_N) && (sn_q != 4'd0);
  assign none_fit = !rem_zero && !(ok_q || ok_d || ok_n);
`else
  assign ok_q     = (rem_q >= CENTS_Q);
  assign ok_d     = (rem_q >= CENTS_D);
  assign ok_n     = (rem_q >= CENTS_N);
  assign none_fit = 1'b0;
`endif

  assign rem_zero = (rem_q == 7'd0);

  always_comb begin
    state_d = state_q;
    coin_d  = coin_q;
    rem_d   = rem_q;
    err_d   = 1'b0;
    tload   = 1'b0;
    tval    = '0;
`ifdef COIN_INVENTORY_EN
    sq_d    = sq_q;
    sd_d    = sd_q;
    sn_d    = sn_q;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef COIN_INVENTORY_EN
        if (bus.restock) begin
          sq_d = 4'(STOCK_INIT);
          sd_d = 4'(STOCK_INIT);
          sn_d = 4'(STOCK_INIT);
        end
`endif
        if (bus.start) begin
          if (amount_ok(bus.amount)) begin
            rem_d   = bus.amount;
            state_d = SELECT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SELECT: begin
        tval = TW'(PULSE_CYCLES - 1);
        unique case (1'b1)
          rem_zero: state_d = DONE;
          none_fit: begin
            err_d   = 1'b1;
            state_d = DONE;
          end
          ok_q: begin
            coin_d  = COIN_Q;
            tload   = 1'b1;
            state_d = PULSE;
          end
          (!ok_q && ok_d): begin
            coin_d  = COIN_D;
            tload   = 1'b1;
            state_d = PULSE;
          end
          default: begin
            coin_d  = COIN_N;
            tload   = 1'b1;
            state_d = PULSE;
          end
        endcase
      end
      PULSE: begin
        if (tzero) begin
          rem_d   = rem_q - coin_cents(coin_q);
          tload   = 1'b1;
          tval    = TW'(GAP_CYCLES - 1);
          state_d = GAP;
`ifdef COIN_INVENTORY_EN
          unique case (coin_q)
            COIN_Q:  sq_d = sq_q - 4'd1;
            COIN_D:  sd_d = sd_q - 4'd1;
            default: sn_d = sn_q - 4'd1;
          endcase
`endif
        end
      end
      GAP: begin
        if (tzero)
          state_d = SELECT;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Drive ejects from the next state so they line up with PULSE exactly.
  always_comb begin
    eq_d = (state_d == PULSE) && (coin_d == COIN_Q);
    ed_d = (state_d == PULSE) && (coin_d == COIN_D);
    en_d = (state_d == PULSE) && (coin_d == COIN_N);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      coin_q  <= COIN_Q;
      rem_q   <= 7'd0;
      err_q   <= 1'b0;
      eq_q    <= 1'b0;
      ed_q    <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      coin_q  <= coin_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      eq_q    <= eq_d;
      ed_q    <= ed_d;
      en_q    <= en_d;
    end
  end

`ifdef COIN_INVENTORY_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sq_q <= 4'(STOCK_INIT);
      sd_q <= 4'(STOCK_INIT);
      sn_q <= 4'(STOCK_INIT);
    end else begin
      sq_q <= sq_d;
      sd_q <= sd_d;
      sn_q <= sn_d;
    end
  end
`endif

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.error     = err_q;
  assign bus.eject_q   = eq_q;
  assign bus.eject_d   = ed_q;
  assign bus.eject_n   = en_q;
  assign bus.remaining = rem_q;

endmodule
